m_key_decoder: RTL and testbench
================================

// Module: m_key_decoder
// PURPOSE
//  PS/2 scancode-set-2 decoder upstream of the game state FSM. Consumes raw bytes from the PS/2 receiver.
//  Tracks E0 (extended) and F0 (break) prefixes. Produces last_key_received for the game logic,
//  a movement direction, and a one-cycle start pulse on SPACE.
//  Prefix sequences that stall are abandoned after a timeout.
// PARAMETERS
//  TIMEOUT_CYC  50_000_000  cycles allowed between prefix byte and following byte before abort (1 s @50 MHz)
//  CNT_W        26          width of timeout counter; must hold TIMEOUT_CYC
// PORTS
//  clock              in   1  system clock; all logic on posedge
//  reset              in   1  synchronous, active-high reset
//  ps2_key_data       in   8  received scancode byte; valid only when ps2_key_pressed=1
//  ps2_key_pressed    in   1  one-cycle strobe, byte available
//  last_key_received  out  8  code byte of most recent make (prefix stripped)
//  last_key_ext       out  1  1 if last_key_received came from an E0 sequence
//  key_held           out  1  1 while the key in last_key_received is held down
//  dir                out  2  00 up, 01 down, 10 left, 11 right
//  dir_valid          out  1  1 while a direction key is held (= key_held & last key is direction)
//  new_key            out  1  one-cycle pulse on a make of a key not already held
//  start_pulse        out  1  one-cycle pulse on a new make of SPACE (29, non-ext)
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; timeout counter=0.
//  States: IDLE, EXT (saw E0), BRK (saw F0), EXT_BRK (saw E0 F0). Bytes are processed only on a strobe cycle.
//  IDLE: E0->EXT; F0->BRK; other byte b = make(b,ext=0).
//  EXT: F0->EXT_BRK; E0->stay EXT; other b = make(b,ext=1), ->IDLE.
//  BRK: b = break(b,ext=0), ->IDLE.
//  EXT_BRK: b = break(b,ext=1), ->IDLE. BRK and EXT_BRK treat E0/F0 bytes as codes (no special case).
//  Timeout: counter clears on every strobe and in IDLE. It increments each non-strobe cycle in a prefix state.
//   On reaching TIMEOUT_CYC-1 -> IDLE, no output change.
//  make(b,e), registered, visible the cycle after the strobe:
//   if key_held && {e,b}=={last_key_ext,last_key_received}: typematic repeat; no output change, no pulses.
//   else: last_key_received<=b, last_key_ext<=e, key_held<=1, new_key<=1 for 1 cycle;
//    start_pulse<=1 for 1 cycle if {e,b}=={0,8'h29}.
//  break(b,e): if {e,b}=={last_key_ext,last_key_received}, key_held<=0. Otherwise ignored; last_key_received is unchanged.
//  Direction map (dir updated with each make, dir_valid combinational from key_held & match):
//   up: E0 75 or 1D(W)
//   down: E0 72 or 1B(S)
//   left: E0 6B or 1C(A)
//   right: E0 74 or 23(D)
//   Other makes leave dir unchanged and make dir_valid=0.
//  new_key and start_pulse are never high for more than one consecutive cycle.
//  Strobe in same cycle as reset: reset wins and the byte is dropped.
//  Reset mid-sequence (e.g. after E0): return to IDLE; the next byte is parsed as non-extended.
// TESTING
//  1 reset asserted 2 cycles -> all outputs 0; first byte 1D -> next cycle last_key=1D, ext=0, held=1, dir=00,
//    dir_valid=1, new_key pulse.
//  2 bytes E0,74 -> last_key=74, ext=1, dir=11, dir_valid=1; then E0,F0,74 -> held=0, dir_valid=0, last_key=74.
//  3 byte 29 -> start_pulse exactly 1 cycle. Repeat 29 x3 (typematic) -> no further start_pulse/new_key.
//    F0,29 then 29 -> start_pulse again.
//  4 hold 1C, then make 23 -> last_key=23, dir=11. Then F0,1C -> ignored (held stays 1); F0,23 -> held=0.
//  5 byte E0, wait TIMEOUT_CYC (test param 16) cycles, then 75 -> parsed non-ext: last_key=75, ext=0, dir_valid=0.
//  6 byte E0, assert reset, send 6B -> last_key=6B, ext=0, dir_valid=0.
//    Strobe coincident with reset -> byte dropped, outputs stay 0.

Source files
------------

// File: rtl/m_key_decoder.sv
// PS/2 scancode-set-2 decoder: strips E0/F0 prefixes and reports the last make,
// its hold state, a movement direction and one-cycle new-key / SPACE start pulses.
module m_key_decoder #(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic [7:0] last_key_received,
  output logic       last_key_ext,
  output logic       key_held,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       new_key,
  output logic       start_pulse
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EXT     = 2'd1;
  localparam logic [1:0] BRK     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] KEY_SPACE = 8'h29;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       key_q, key_d;
  logic             ext_q, ext_d;
  logic             held_q, held_d;
  logic [1:0]       dir_q, dir_d;
  logic             newKey_q, newKey_d;
  logic             start_q, start_d;

  logic             doMake, doBreak, codeExt;
  logic [2:0]       makeDir;

  // Returns {is_direction, dir} for an {ext, code} pair.
  function automatic logic [2:0] dirLookup(input logic e, input logic [7:0] b);
    logic [2:0] r;
    r = 3'b000;
    case ({e, b})
      {1'b1, 8'h75}, {1'b0, 8'h1D}: r = 3'b100;
      {1'b1, 8'h72}, {1'b0, 8'h1B}: r = 3'b101;
      {1'b1, 8'h6B}, {1'b0, 8'h1C}: r = 3'b110;
      {1'b1, 8'h74}, {1'b0, 8'h23}: r = 3'b111;
      default:                      r = 3'b000;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    doMake   = 1'b0;
    doBreak  = 1'b0;
    codeExt  = 1'b0;
    if (ps2_key_pressed) begin
      case (state_q)
        IDLE: begin
          if (ps2_key_data == PFX_EXT)      state_d = EXT;
          else if (ps2_key_data == PFX_BRK) state_d = BRK;
          else                              doMake  = 1'b1;
        end
        EXT: begin
          if (ps2_key_data == PFX_BRK) begin
            state_d = EXT_BRK;
          end else if (ps2_key_data != PFX_EXT) begin
            doMake  = 1'b1;
            codeExt = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          doBreak = 1'b1;
          state_d = IDLE;
        end
        default: begin
          doBreak = 1'b1;
          codeExt = 1'b1;
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE) begin
      // A stalled prefix is abandoned silently; the next byte starts a fresh sequence.
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    key_d    = key_q;
    ext_d    = ext_q;
    held_d   = held_q;
    dir_d    = dir_q;
    newKey_d = 1'b0;
    start_d  = 1'b0;
    makeDir  = dirLookup(codeExt, ps2_key_data);
    // A make of the key already held is typematic repeat and changes nothing.
    if (doMake && !(held_q && {codeExt, ps2_key_data} == {ext_q, key_q})) begin
      key_d    = ps2_key_data;
      ext_d    = codeExt;
      held_d   = 1'b1;
      newKey_d = 1'b1;
      start_d  = ({codeExt, ps2_key_data} == {1'b0, KEY_SPACE});
      if (makeDir[2]) dir_d = makeDir[1:0];
    end
    if (doBreak && {codeExt, ps2_key_data} == {ext_q, key_q}) begin
      held_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      key_q    <= '0;
      ext_q    <= 1'b0;
      held_q   <= 1'b0;
      dir_q    <= 2'b00;
      newKey_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      ext_q    <= ext_d;
      held_q   <= held_d;
      dir_q    <= dir_d;
      newKey_q <= newKey_d;
      start_q  <= start_d;
    end
  end

  logic [2:0] heldDir;
  assign heldDir = dirLookup(ext_q, key_q);

  assign last_key_received = key_q;
  assign last_key_ext      = ext_q;
  assign key_held          = held_q;
  assign dir               = dir_q;
  assign dir_valid         = held_q & heldDir[2];
  assign new_key           = newKey_q;
  assign start_pulse       = start_q;

endmodule

// File: tb/tb_m_key_decoder.sv
// Bench for m_key_decoder: directed scenarios then random byte streams, all checked
// cycle by cycle against a queue-based prefix model with a direction lookup table.
module tb_m_key_decoder;

  localparam int TO = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ps2_key_data = 8'h00;
  logic       ps2_key_pressed = 1'b0;
  logic [7:0] last_key_received;
  logic       last_key_ext;
  logic       key_held;
  logic [1:0] dir;
  logic       dir_valid;
  logic       new_key;
  logic       start_pulse;

  m_key_decoder #(.TIMEOUT_CYC(TO), .CNT_W(26)) dut (
    .clock(clock),
    .reset(reset),
    .ps2_key_data(ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed),
    .last_key_received(last_key_received),
    .last_key_ext(last_key_ext),
    .key_held(key_held),
    .dir(dir),
    .dir_valid(dir_valid),
    .new_key(new_key),
    .start_pulse(start_pulse)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state: pending prefix bytes, last make and expected pulses.
  logic [7:0] pending[$];
  logic [7:0] mKey;
  logic       mExt, mHeld, mNew, mStart;
  logic [1:0] mDir;
  int         idleGap;
  int         dirOf[int];

  function automatic int keyIdx(input logic e, input logic [7:0] b);
    return (e ? 256 : 0) + int'(b);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll(input string tag);
    logic expValid;
    expValid = mHeld && dirOf.exists(keyIdx(mExt, mKey));
    checkOutput({tag, " last_key"}, 32'(last_key_received), 32'(mKey));
    checkOutput({tag, " ext"}, 32'(last_key_ext), 32'(mExt));
    checkOutput({tag, " held"}, 32'(key_held), 32'(mHeld));
    checkOutput({tag, " dir"}, 32'(dir), 32'(mDir));
    checkOutput({tag, " dir_valid"}, 32'(dir_valid), 32'(expValid));
    checkOutput({tag, " new_key"}, 32'(new_key), 32'(mNew));
    checkOutput({tag, " start"}, 32'(start_pulse), 32'(mStart));
  endtask

  task automatic modelMake(input logic [7:0] b, input logic e);
    if (mHeld && e == mExt && b == mKey) return;
    mKey   = b;
    mExt   = e;
    mHeld  = 1'b1;
    mNew   = 1'b1;
    mStart = (!e && b == 8'h29);
    if (dirOf.exists(keyIdx(e, b))) mDir = 2'(dirOf[keyIdx(e, b)]);
  endtask

  task automatic modelStrobe(input logic [7:0] b);
    logic hasE0, hasF0;
    mNew   = 1'b0;
    mStart = 1'b0;
    if (pending.size() > 0 && idleGap >= TO - 1) pending.delete();
    hasF0 = (pending.size() > 0) && (pending[pending.size()-1] == 8'hF0);
    hasE0 = 1'b0;
    foreach (pending[i]) if (pending[i] == 8'hE0) hasE0 = 1'b1;
    if (hasF0) begin
      if (hasE0 == mExt && b == mKey) mHeld = 1'b0;
      pending.delete();
    end else if (b == 8'hE0) begin
      if (!hasE0) pending.push_back(b);
    end else if (b == 8'hF0) begin
      pending.push_back(b);
    end else begin
      modelMake(b, hasE0);
      pending.delete();
    end
  endtask

  // Drive one strobed byte, then gap idle cycles; outputs checked every cycle.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    modelStrobe(b);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    @(negedge clock);
    compareAll($sformatf("byte %02h", b));
    mNew    = 1'b0;
    mStart  = 1'b0;
    idleGap = 0;
    repeat (gap) begin
      ps2_key_pressed = 1'b0;
      @(negedge clock);
      idleGap++;
      compareAll($sformatf("after %02h", b));
    end
  endtask

  task automatic resetDut(input int cycles, input logic strobe, input logic [7:0] b);
    reset           = 1'b1;
    ps2_key_pressed = strobe;
    ps2_key_data    = b;
    pending.delete();
    mKey = 8'h00; mExt = 1'b0; mHeld = 1'b0; mDir = 2'b00; mNew = 1'b0; mStart = 1'b0;
    idleGap = 0;
    repeat (cycles) begin
      @(negedge clock);
      compareAll("reset");
    end
    reset           = 1'b0;
    ps2_key_pressed = 1'b0;
  endtask

  logic [7:0] pool[12];

  initial begin
    dirOf[keyIdx(1'b1, 8'h75)] = 0; dirOf[keyIdx(1'b0, 8'h1D)] = 0;
    dirOf[keyIdx(1'b1, 8'h72)] = 1; dirOf[keyIdx(1'b0, 8'h1B)] = 1;
    dirOf[keyIdx(1'b1, 8'h6B)] = 2; dirOf[keyIdx(1'b0, 8'h1C)] = 2;
    dirOf[keyIdx(1'b1, 8'h74)] = 3; dirOf[keyIdx(1'b0, 8'h23)] = 3;
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'h5A};

    @(negedge clock);
    resetDut(2, 1'b0, 8'h00);

    applyStimulus(8'h1D, 2);
    checkOutput("t1 key", 32'(last_key_received), 32'h1D);
    checkOutput("t1 dir_valid", 32'(dir_valid), 32'd1);

    applyStimulus(8'hE0, 1); applyStimulus(8'h74, 1);
    checkOutput("t2 dir", 32'(dir), 32'd3);
    applyStimulus(8'hE0, 0); applyStimulus(8'hF0, 0); applyStimulus(8'h74, 1);
    checkOutput("t2 key", 32'(last_key_received), 32'h74);
    checkOutput("t2 held", 32'(key_held), 32'd0);

    applyStimulus(8'h29, 2);
    repeat (3) applyStimulus(8'h29, 1);
    applyStimulus(8'hF0, 0); applyStimulus(8'h29, 1);
    applyStimulus(8'h29, 2);

    applyStimulus(8'h1C, 1); applyStimulus(8'h23, 1);
    checkOutput("t4 dir", 32'(dir), 32'd3);
    applyStimulus(8'hF0, 0); applyStimulus(8'h1C, 1);
    checkOutput("t4 held kept", 32'(key_held), 32'd1);
    applyStimulus(8'hF0, 0); applyStimulus(8'h23, 1);
    checkOutput("t4 held released", 32'(key_held), 32'd0);

    applyStimulus(8'hE0, TO); applyStimulus(8'h75, 1);
    checkOutput("t5 ext", 32'(last_key_ext), 32'd0);
    checkOutput("t5 dir_valid", 32'(dir_valid), 32'd0);

    applyStimulus(8'hE0, 3); applyStimulus(8'h72, 1);
    checkOutput("short gap ext", 32'(last_key_ext), 32'd1);

    applyStimulus(8'hE0, 0);
    resetDut(1, 1'b0, 8'h00);
    applyStimulus(8'h6B, 1);
    checkOutput("t6 key", 32'(last_key_received), 32'h6B);
    checkOutput("t6 ext", 32'(last_key_ext), 32'd0);
    resetDut(1, 1'b1, 8'h29);
    @(negedge clock);
    compareAll("post reset strobe");
    checkOutput("t6 dropped", 32'(last_key_received), 32'h00);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] b;
      int gap;
      if ($urandom_range(0, 59) == 0) resetDut(1, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 11)]);
      b   = ($urandom_range(0, 4) == 0) ? mKey : pool[$urandom_range(0, 11)];
      gap = ($urandom_range(0, 9) == 0) ? TO + 3 : int'($urandom_range(0, 3));
      applyStimulus(b, gap);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
